axi_sram_slave: RTL and testbench
=================================

// Module: axi_sram_slave
// PURPOSE: AXI3 slave memory: the responder end of the CPU bridge's AXI master port. Backs simulation/SoC RAM with a
//   single-port word array, serving I/D-cache line refills, D-cache writebacks and uncached single beats. One burst at a time.
// PARAMETERS:
//   ID_W    4   width of arid/rid/awid/bid
//   ADDR_W  14  word-index bits; capacity 2^ADDR_W x 32b (64 KB default); index = addr[ADDR_W+1:2]
// PORTS: (size/burst/lock/cache/prot/wid are not ported: every burst is INCR, every beat is a full 32b word)
//   aclk     in   1      clock; all logic on rising edge
//   areset   in   1      synchronous active-high reset
//   arid     in   ID_W   read ID
//   araddr   in   32     read start address; bits[1:0] ignored
//   arlen    in   8      beats-1 (0..255)
//   arvalid  in   1      read request valid
//   arready  out  1      read request accepted
//   rid      out  ID_W   = latched arid
//   rdata    out  32     read word
//   rresp    out  2      always 2'b00 OKAY
//   rlast    out  1      final beat of burst
//   rvalid   out  1      read data valid
//   rready   in   1      master accepts data
//   awid     in   ID_W   write ID
//   awaddr   in   32     write start address; bits[1:0] ignored
//   awlen    in   8      beats-1
//   awvalid  in   1      write request valid
//   awready  out  1      write request accepted
//   wdata    in   32     write word
//   wstrb    in   4      byte enables; bit i -> wdata[8i+7:8i]
//   wlast    in   1      master's last-beat flag (checked, never used to terminate)
//   wvalid   in   1      write data valid
//   wready   out  1      slave accepts write data
//   bid      out  ID_W   = latched awid
//   bresp    out  2      2'b00 OKAY, 2'b10 SLVERR on wlast mismatch
//   bvalid   out  1      write response valid
//   bready   in   1      master accepts response
// BEHAVIOUR:
//   - FSM IDLE/WR/BRESP/RD_ADDR/RD_DATA. Reset: IDLE; rvalid,rlast,wready,bvalid=0; rdata,rid,bid,rresp,bresp=0; memory NOT cleared.
//   - Combinational: awready=(IDLE); arready=(IDLE && !awvalid). Same-cycle awvalid+arvalid: write first (writeback before refill).
//   - AW handshake: latch awid, word index, awlen; cnt=0; err=0; -> WR. wready=1 only in WR.
//   - WR, each W handshake: write strobed bytes at idx; err|=(wlast!=(cnt==len)); idx++, cnt++. Beat cnt==len: -> BRESP,
//     bvalid=1, bresp=err?2'b10:2'b00. Exactly len+1 beats always written. bvalid&&bready -> IDLE.
//   - AR handshake (cycle 0): latch arid, idx, arlen, cnt=0 -> RD_ADDR. RD_ADDR (cycle 1): sync read mem[idx] -> RD_DATA.
//     RD_DATA (cycle 2): rvalid=1, rdata=word, rlast=(cnt==len); rdata/rlast/rid held stable while rready=0.
//     rvalid&&rready: last -> IDLE, rvalid=0; else idx++, cnt++ -> RD_ADDR. Throughput 1 beat per 2 cycles.
//   - idx increments modulo 2^ADDR_W (wraps to word 0 inside a burst); high address bits ignored, no decode errors.
//   - areset mid-burst: next edge -> IDLE, valids dropped, burst abandoned; completed writes remain in memory.
// TESTING:
//   1. AW 0x10 len0 id3; W 0xDEADBEEF strb F wlast1 -> B bid3 bresp00; AR 0x10 id5 -> rvalid 2 cycles after AR, DEADBEEF rid5 rlast1.
//   2. Preload 0x100..0x10C=1,2,3,4; AR 0x100 len3; rready low 3 cycles on beat 2 -> beats 1,2,3,4 in order, beat 2 stable, rlast only beat 4.
//   3. Word 0x20=0x11223344; write 0x0000AB00 strb 4'b0010 -> readback 0x1122AB44.
//   4. awvalid+arvalid same cycle in IDLE, same address -> AW taken, arready=0 until B handshake, read returns newly written data.
//   5. AW len3 with wlast on beat 3 and not beat 4 -> all 4 words written, bresp 2'b10; next clean burst -> 2'b00.
//   6. areset after first R beat of len3 burst -> rvalid=0, IDLE, arready=1 next cycle; top-word (idx 2^ADDR_W-1) len1 read -> 2nd beat from word 0.

Source files
------------

// File: rtl/axi_sram_slave.sv
// axi_sram_slave
//   AXI3 responder backing a single-port 2^ADDR_W x 32b word array. It serves
//   cache line refills, writebacks and uncached single beats, one burst at a
//   time. Every burst is INCR and every beat is a full word with byte strobes.
//
// Ports
//   aclk, areset                  clock, synchronous active-high reset
//   arid/araddr/arlen/arvalid     read address channel in; arready out
//   rid/rdata/rresp/rlast/rvalid  read data channel out; rready in
//   awid/awaddr/awlen/awvalid     write address channel in; awready out
//   wdata/wstrb/wlast/wvalid      write data channel in; wready out
//   bid/bresp/bvalid              write response channel out; bready in
//
// Word index is addr[ADDR_W+1:2]. The index wraps modulo 2^ADDR_W inside a
// burst, and high address bits are ignored. A write burst always takes
// exactly len+1 beats. If wlast disagrees with the beat count, bresp is
// SLVERR. A read beat takes two cycles: the array read, then the beat is
// presented.
module axi_sram_slave #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 14
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [ID_W-1:0]   arid,
  input  logic [31:0]       araddr,
  input  logic [7:0]        arlen,
  input  logic              arvalid,
  output logic              arready,
  output logic [ID_W-1:0]   rid,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  input  logic [ID_W-1:0]   awid,
  input  logic [31:0]       awaddr,
  input  logic [7:0]        awlen,
  input  logic              awvalid,
  output logic              awready,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [ID_W-1:0]   bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_BRESP,
    S_RD_ADDR,
    S_RD_DATA
  } state_t;

  state_t state, state_nx;

  logic [31:0]       mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] idx;
  logic [7:0]        cnt;
  logic [7:0]        len;
  logic              err;
  logic              err_nx;
  logic              last_beat;
  logic              aw_hs, ar_hs, w_hs, r_hs, b_hs;

  // Address bits outside the word index carry no meaning here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{awaddr[31:ADDR_W+2], awaddr[1:0],
                              araddr[31:ADDR_W+2], araddr[1:0]};

  assign last_beat = (cnt == len);
  assign aw_hs     = awvalid && awready;
  assign ar_hs     = arvalid && arready;
  assign w_hs      = wvalid && wready;
  assign r_hs      = rvalid && rready;
  assign b_hs      = bvalid && bready;
  assign err_nx    = err | (wlast != last_beat);

  // State register
  always_ff @(posedge aclk) begin
    if (areset) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        // Write wins a same-cycle tie so a writeback lands before the refill.
        if (awvalid)      state_nx = S_WR;
        else if (arvalid) state_nx = S_RD_ADDR;
      end
      S_WR:      if (w_hs && last_beat) state_nx = S_BRESP;
      S_BRESP:   if (b_hs) state_nx = S_IDLE;
      S_RD_ADDR: state_nx = S_RD_DATA;
      S_RD_DATA: if (r_hs) state_nx = last_beat ? S_IDLE : S_RD_ADDR;
      default:   state_nx = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    awready = (state == S_IDLE);
    arready = (state == S_IDLE) && !awvalid;
    wready  = (state == S_WR);
    bvalid  = (state == S_BRESP);
    rvalid  = (state == S_RD_DATA);
    rlast   = (state == S_RD_DATA) && last_beat;
    rresp   = 2'b00;
  end

  // Burst bookkeeping and registered response fields
  always_ff @(posedge aclk) begin
    if (areset) begin
      idx   <= '0;
      cnt   <= '0;
      len   <= '0;
      err   <= 1'b0;
      rid   <= '0;
      bid   <= '0;
      bresp <= '0;
      rdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (aw_hs) begin
            bid <= awid;
            idx <= awaddr[ADDR_W+1:2];
            len <= awlen;
            cnt <= '0;
            err <= 1'b0;
          end else if (ar_hs) begin
            rid <= arid;
            idx <= araddr[ADDR_W+1:2];
            len <= arlen;
            cnt <= '0;
          end
        end
        S_WR: begin
          if (w_hs) begin
            err <= err_nx;
            idx <= idx + ADDR_W'(1);
            cnt <= cnt + 8'd1;
            if (last_beat) bresp <= err_nx ? 2'b10 : 2'b00;
          end
        end
        S_RD_ADDR: rdata <= mem[idx];
        S_RD_DATA: begin
          if (r_hs && !last_beat) begin
            idx <= idx + ADDR_W'(1);
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Storage is never cleared; only strobed bytes are written.
  always_ff @(posedge aclk) begin
    if (w_hs && !areset) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
module tb_axi_sram_slave;
  localparam int ID_W = 4;
  localparam int AW   = 14;
  localparam int NW   = 1 << AW;

  logic            aclk = 1'b0;
  logic            areset;
  logic [ID_W-1:0] arid, rid, awid, bid;
  logic [31:0]     araddr, rdata, awaddr, wdata;
  logic [7:0]      arlen, awlen;
  logic            arvalid, arready, rlast, rvalid, rready;
  logic [1:0]      rresp, bresp;
  logic            awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]      wstrb;

  always #5 aclk = ~aclk;

  axi_sram_slave #(.ID_W(ID_W), .ADDR_W(AW)) dut (
    .aclk(aclk), .areset(areset),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out", name);
  endtask

  typedef struct packed { logic [3:0] id; logic [31:0] data; logic last; } rexp_t;
  typedef struct packed { logic [3:0] id; logic [1:0] resp; } bexp_t;

  rexp_t rq[$];
  bexp_t bq[$];

  // Reference memory and per-beat write stimulus
  logic [31:0] mm [NW];
  logic [31:0] wd [256];
  logic [3:0]  ws [256];
  logic        wl [256];
  int          nb_hs = 0;
  int          ar_b_snap = 0;

  function automatic void model_write(input logic [31:0] addr, input int len, input logic [3:0] id);
    int w;
    bit err;
    w = int'((addr >> 2) % NW);
    err = 0;
    for (int b = 0; b <= len; b++) begin
      for (int i = 0; i < 4; i++)
        if (ws[b][i]) mm[w][8*i +: 8] = wd[b][8*i +: 8];
      if (wl[b] != (b == len)) err = 1;
      w = (w + 1) % NW;
    end
    bq.push_back('{id: id, resp: (err ? 2'b10 : 2'b00)});
  endfunction

  function automatic void model_read(input logic [31:0] addr, input int len, input logic [3:0] id, input int npush);
    int w;
    w = int'((addr >> 2) % NW);
    for (int b = 0; b < npush; b++) begin
      rq.push_back('{id: id, data: mm[w], last: (b == len)});
      w = (w + 1) % NW;
    end
  endfunction

  function automatic void fill_beats(input int len, input logic [31:0] base);
    for (int b = 0; b <= len; b++) begin
      wd[b] = base + 32'(b);
      ws[b] = 4'hF;
      wl[b] = (b == len);
    end
  endfunction

  task automatic drive_write(input logic [31:0] addr, input int len, input logic [3:0] id, input bit gaps);
    int t;
    @(posedge aclk); #1;
    awvalid = 1'b1; awaddr = addr; awlen = 8'(len); awid = id;
    t = 0;
    forever begin
      @(negedge aclk);
      if (awready) break;
      if (++t > 2000) begin timeout_fail("aw_handshake"); break; end
    end
    @(posedge aclk); #1;
    awvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        wvalid = 1'b0;
        @(posedge aclk); #1;
      end
      wvalid = 1'b1; wdata = wd[b]; wstrb = ws[b]; wlast = wl[b];
      t = 0;
      forever begin
        @(negedge aclk);
        if (wready) break;
        if (++t > 2000) begin timeout_fail("w_handshake"); break; end
      end
      @(posedge aclk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
    bready = 1'b1;
    t = 0;
    forever begin
      @(negedge aclk);
      if (bvalid) break;
      if (++t > 2000) begin timeout_fail("b_handshake"); break; end
    end
    @(posedge aclk); #1;
    bready = 1'b0;
  endtask

  // mode 0: always ready; 1: random ready; 2: hold ready low 3 valid cycles on beat 2
  task automatic drive_read(input logic [31:0] addr, input int len, input logic [3:0] id, input int mode, input int take);
    int t, got, cyc, stall_left;
    @(posedge aclk); #1;
    arvalid = 1'b1; araddr = addr; arlen = 8'(len); arid = id;
    t = 0;
    forever begin
      @(negedge aclk);
      if (arready) break;
      if (++t > 2000) begin timeout_fail("ar_handshake"); break; end
    end
    ar_b_snap = nb_hs;
    @(posedge aclk); #1;
    arvalid = 1'b0;
    got = 0; cyc = 0; stall_left = 3;
    rready = (mode != 2);
    while (got < take) begin
      @(negedge aclk);
      if (cyc == 0) chk("rd_latency_c1", rvalid, 1'b0);
      if (cyc == 1) chk("rd_latency_c2", rvalid, 1'b1);
      if (rvalid && rready) got++;
      @(posedge aclk); #1;
      cyc++;
      case (mode)
        1: rready = ($urandom_range(0, 3) != 0);
        2: if (got == 1 && stall_left > 0) begin
             rready = 1'b0;
             if (rvalid) stall_left--;
           end else rready = 1'b1;
        default: rready = 1'b1;
      endcase
      if (cyc > 4000) begin timeout_fail("r_beats"); break; end
    end
    rready = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] addr, input int len, input logic [3:0] id, input bit gaps);
    model_write(addr, len, id);
    drive_write(addr, len, id, gaps);
  endtask

  task automatic do_read(input logic [31:0] addr, input int len, input logic [3:0] id, input int mode);
    model_read(addr, len, id, len + 1);
    drive_read(addr, len, id, mode, len + 1);
  endtask

  // Scoreboard monitor
  logic        stall_prev = 1'b0;
  logic [31:0] p_data;
  logic        p_last;
  logic [3:0]  p_id;

  always @(negedge aclk) begin : monitor
    rexp_t re;
    bexp_t be;
    if (areset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("r_hold_valid", rvalid, 1'b1);
        chk("r_hold_data", rdata, p_data);
        chk("r_hold_last", rlast, p_last);
        chk("r_hold_id", rid, p_id);
      end
      if (rvalid && rready) begin
        if (rq.size() == 0) begin
          checks++; failures++;
          $display("FAIL r_unexpected: got beat %0h with no expected beat", rdata);
        end else begin
          re = rq.pop_front();
          chk("r_data", rdata, re.data);
          chk("r_id", rid, re.id);
          chk("r_last", rlast, re.last);
          chk("r_resp", rresp, 2'b00);
        end
      end
      if (bvalid && bready) begin
        nb_hs++;
        if (bq.size() == 0) begin
          checks++; failures++;
          $display("FAIL b_unexpected: got bid %0h with no expected response", bid);
        end else begin
          be = bq.pop_front();
          chk("b_id", bid, be.id);
          chk("b_resp", bresp, be.resp);
        end
      end
      stall_prev = rvalid && !rready;
      p_data = rdata; p_last = rlast; p_id = rid;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int snap, len, w, off;
    logic [15:0] hi;
    logic [1:0]  lo;
    logic [13:0] wi;
    logic [31:0] addr;

    areset = 1'b1;
    arid = '0; araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_rlast", rlast, 1'b0);
    chk("rst_wready", wready, 1'b0);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_rid", rid, 4'h0);
    chk("rst_bid", bid, 4'h0);
    chk("rst_bresp", bresp, 2'b00);
    chk("rst_awready", awready, 1'b1);
    chk("rst_arready", arready, 1'b1);
    @(posedge aclk); #1;
    areset = 1'b0;

    // Fill words NW-64..NW-1 and 0..127 with one wrapping burst
    for (int b = 0; b < 192; b++) begin wd[b] = $urandom; ws[b] = 4'hF; wl[b] = (b == 191); end
    do_write(32'((NW - 64) * 4), 191, 4'h0, 1'b0);

    // 1: single beat write then read
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF; wl[0] = 1'b1;
    do_write(32'h10, 0, 4'h3, 1'b0);
    do_read(32'h10, 0, 4'h5, 0);

    // 2: four-beat read with back-pressure on beat 2
    fill_beats(3, 32'd1);
    do_write(32'h100, 3, 4'h1, 1'b0);
    do_read(32'h100, 3, 4'h2, 2);

    // 3: byte-strobe merge
    wd[0] = 32'h11223344; ws[0] = 4'hF; wl[0] = 1'b1;
    do_write(32'h20, 0, 4'h4, 1'b0);
    wd[0] = 32'h0000AB00; ws[0] = 4'b0010; wl[0] = 1'b1;
    do_write(32'h20, 0, 4'h4, 1'b0);
    do_read(32'h20, 0, 4'h6, 0);

    // 4: simultaneous AW and AR to the same word; write must complete first
    wd[0] = $urandom; ws[0] = 4'hF; wl[0] = 1'b1;
    model_write(32'h40, 0, 4'h6);
    model_read(32'h40, 0, 4'h7, 1);
    snap = nb_hs;
    fork
      drive_write(32'h40, 0, 4'h6, 1'b0);
      drive_read(32'h40, 0, 4'h7, 0, 1);
    join
    chk("t4_ar_after_b", ar_b_snap, snap + 1);

    // 5: early wlast gives SLVERR but all beats land; clean burst after is OKAY
    fill_beats(3, 32'hA0A0_0000);
    wl[2] = 1'b1; wl[3] = 1'b0;
    do_write(32'h30, 3, 4'h9, 1'b0);
    do_read(32'h30, 3, 4'h8, 1);
    fill_beats(3, 32'hB0B0_0000);
    do_write(32'h30, 3, 4'hA, 1'b0);

    // 6: reset after first beat of a 4-beat read, then a wrapping read
    model_read(32'h44, 3, 4'h4, 1);
    drive_read(32'h44, 3, 4'h4, 0, 1);
    areset = 1'b1;
    @(posedge aclk); #1;
    areset = 1'b0;
    @(negedge aclk);
    chk("t6_rvalid", rvalid, 1'b0);
    chk("t6_rlast", rlast, 1'b0);
    chk("t6_arready", arready, 1'b1);
    chk("t6_awready", awready, 1'b1);
    chk("t6_rdata", rdata, 32'h0);
    do_read(32'((NW - 1) * 4), 1, 4'h2, 0);

    // Random traffic inside the filled window, including wraps and high address bits
    for (int it = 0; it < 40; it++) begin
      off = $urandom_range(0, 63);
      w = (NW - 32 + off) % NW;
      wi = 14'(w);
      hi = 16'($urandom);
      lo = 2'($urandom);
      addr = {hi, wi, lo};
      len = $urandom_range(0, 7);
      if ($urandom_range(0, 1) == 0) begin
        for (int b = 0; b <= len; b++) begin
          wd[b] = $urandom; ws[b] = 4'($urandom); wl[b] = (b == len);
        end
        if ($urandom_range(0, 4) == 0) begin
          off = $urandom_range(0, len);
          wl[off] = !wl[off];
        end
        do_write(addr, len, 4'($urandom), 1'b1);
      end else begin
        do_read(addr, len, 4'($urandom), 1);
      end
    end

    repeat (5) @(posedge aclk);
    chk("rq_drained", 32'(rq.size()), 32'd0);
    chk("bq_drained", 32'(bq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
